sorted_vector_serializer: RTL and testbench

- Drains the parallel output of the 8-input bitonic sort/merge stage (valid-only, no backpressure) into a one-element-per-beat stream with valid/ready flow control.
- Buffers up to two complete sorted vectors.
- Emits the first K elements of each vector in a selectable order, with first/last markers.
- Sits at the tail of the sorting network, feeding the downstream consumer.

---
 rtl/sorted_vector_serializer.sv | 105 ++++++++++
 tb/tb_sorted_vector_serializer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_vector_serializer.sv
// Serializes sorted 8-element vectors from the bitonic stage into a valid/ready
// element stream, buffering up to two vectors and emitting the first K of each.
module sorted_vector_serializer #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned LABEL_WIDTH = 3,
   parameter int unsigned K           = 8,
   parameter int unsigned EMIT_ORDER  = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     x_valid,
   input  logic [DATA_WIDTH*8-1:0]  x,
   input  logic [LABEL_WIDTH*8-1:0] x_label,
   output logic [DATA_WIDTH-1:0]    y_data,
   output logic [LABEL_WIDTH-1:0]   y_label,
   output logic                     y_valid,
   input  logic                     y_ready,
   output logic                     y_first,
   output logic                     y_last,
   output logic                     busy,
   output logic                     overflow
);

   generate
      if (K < 1 || K > 8) begin : g_bad_k
         $error("sorted_vector_serializer: K must be in 1..8");
      end
   endgenerate

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [2:0] LAST_IDX = 3'(K - 1);

   state_t state, state_nxt;
   logic rd_ptr, wr_ptr;
   logic [2:0] idx;
   logic [2:0] pos;
   logic xfer, final_beat, push, drop;

   logic [DATA_WIDTH-1:0]  mem_d [2][8];
   logic [LABEL_WIDTH-1:0] mem_l [2][8];

   assign xfer       = y_valid & y_ready;
   assign final_beat = xfer & (idx == LAST_IDX);
   // A full FIFO can still take a vector when the head pops on the same edge
   assign push       = x_valid & ((state != FULL) | final_beat);
   assign drop       = x_valid & (state == FULL) & ~final_beat;

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (x_valid) state_nxt = ONE;
         ONE: begin
            if (x_valid && !final_beat)      state_nxt = FULL;
            else if (!x_valid && final_beat) state_nxt = EMPTY;
         end
         FULL:    if (final_beat && !x_valid) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         idx      <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= ~wr_ptr;
         if (final_beat) begin
            rd_ptr <= ~rd_ptr;
            idx    <= '0;
         end else if (xfer) begin
            idx <= idx + 3'd1;
         end
         if (drop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         for (int unsigned i = 0; i < 8; i++) begin
            mem_d[wr_ptr][i] <= x[i*DATA_WIDTH +: DATA_WIDTH];
            mem_l[wr_ptr][i] <= x_label[i*LABEL_WIDTH +: LABEL_WIDTH];
         end
      end
   end

   assign pos = (EMIT_ORDER != 0) ? (3'd7 - idx) : idx;

   // Outputs are gated by y_valid so they read zero when nothing is queued
   assign y_valid = (state != EMPTY);
   assign busy    = y_valid;
   assign y_data  = y_valid ? mem_d[rd_ptr][pos] : '0;
   assign y_label = y_valid ? mem_l[rd_ptr][pos] : '0;
   assign y_first = y_valid & (idx == 3'd0);
   assign y_last  = y_valid & (idx == LAST_IDX);

endmodule

// File: tb/tb_sorted_vector_serializer.sv
// Directed bench for sorted_vector_serializer: default-parameter instance plus
// a K=3, reversed-order instance.
module tb_sorted_vector_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, x_valid, y_ready;
   logic [63:0] x;
   logic [23:0] x_label;
   logic [7:0]  y_data;
   logic [2:0]  y_label;
   logic        y_valid, y_first, y_last, busy, overflow;

   logic        x2_valid, y2_ready;
   logic [63:0] x2;
   logic [23:0] x2_label;
   logic [7:0]  y2_data;
   logic [2:0]  y2_label;
   logic        y2_valid, y2_first, y2_last, busy2, overflow2;

   sorted_vector_serializer dut (
      .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .x_label(x_label),
      .y_data(y_data), .y_label(y_label), .y_valid(y_valid), .y_ready(y_ready),
      .y_first(y_first), .y_last(y_last), .busy(busy), .overflow(overflow)
   );

   sorted_vector_serializer #(.K(3), .EMIT_ORDER(1)) dut_k3 (
      .clk(clk), .rst(rst), .x_valid(x2_valid), .x(x2), .x_label(x2_label),
      .y_data(y2_data), .y_label(y2_label), .y_valid(y2_valid), .y_ready(y2_ready),
      .y_first(y2_first), .y_last(y2_last), .busy(busy2), .overflow(overflow2)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Beats seen on the default instance, as {first,last,label,data}
   logic [12:0] got[$];
   logic [12:0] exp_q[$];

   always @(negedge clk)
      if (y_valid && y_ready) got.push_back({y_first, y_last, y_label, y_data});

   function automatic logic [12:0] beat(input logic f, input logic l, input int lab, input int d);
      return {f, l, 3'(lab), 8'(d)};
   endfunction

   function automatic logic [63:0] mkd(input int base, input int step);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(base + step*i);
      return r;
   endfunction

   function automatic logic [23:0] mkl(input int base);
      logic [23:0] r;
      for (int i = 0; i < 8; i++) r[i*3 +: 3] = 3'(base + i);
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic send(input int base, input int step, input int lbase);
      x_valid = 1'b1;
      x       = mkd(base, step);
      x_label = mkl(lbase);
   endtask

   task automatic add_vec(input int base, input int step, input int lbase);
      for (int i = 0; i < 8; i++)
         exp_q.push_back(beat(i == 0, i == 7, lbase + i, base + step*i));
   endtask

   task automatic clear_q();
      got.delete();
      exp_q.delete();
   endtask

   task automatic cmp_stream(input string tag);
      check({tag, "_count"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         check(tag, {i[15:0], 3'b0, got[i]}, {i[15:0], 3'b0, exp_q[i]});
   endtask

   task automatic drain(input string tag);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (!y_valid) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check({tag, "_drained"}, done, 1);
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; x_valid = 1'b0; x = '0; x_label = '0; y_ready = 1'b1;
      x2_valid = 1'b0; x2 = '0; x2_label = '0; y2_ready = 1'b1;
      cyc(); cyc();
      mid();
      check("rst_valid", y_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      check("rst_marks", {y_first, y_last}, 0);
      check("rst_out", {y_label, y_data}, 0);
      check("rst_valid2", y2_valid, 0);
      rst = 1'b0;
      cyc();

      // single vector, no stall
      send(0, 10, 0);
      cyc();
      x_valid = 1'b0;
      for (int b = 0; b < 8; b++) begin
         mid();
         check("t1_valid", y_valid, 1);
         check("t1_beat", {y_first, y_last, y_label, y_data}, beat(b == 0, b == 7, b, 10*b));
         cyc();
      end
      mid();
      check("t1_idle", {y_valid, busy}, 0);
      cyc();

      // alternating backpressure
      send(0, 10, 0);
      cyc();
      x_valid = 1'b0;
      for (int c = 0; c < 16; c++) begin
         y_ready = (c % 2 == 1);
         mid();
         check("t2_valid", y_valid, 1);
         check("t2_beat", {y_first, y_last, y_label, y_data},
               beat(c/2 == 0, c/2 == 7, c/2, 10*(c/2)));
         cyc();
      end
      y_ready = 1'b1;
      mid();
      check("t2_idle", y_valid, 0);
      cyc();

      // overflow on third back-to-back vector
      clear_q();
      send(0, 1, 0);   cyc();
      send(50, 2, 1);  cyc();
      send(200, 1, 5); cyc();
      x_valid = 1'b0;
      mid();
      check("t3_ovf", overflow, 1);
      cyc();
      drain("t3");
      add_vec(0, 1, 0);
      add_vec(50, 2, 1);
      cmp_stream("t3");
      check("t3_ovf_sticky", overflow, 1);

      // reset mid-stream with a queued vector and overflow set
      clear_q();
      send(0, 1, 0);  cyc();
      send(50, 2, 1); cyc();
      x_valid = 1'b0;
      cyc(); cyc();
      mid();
      check("t6_pre_ovf", overflow, 1);
      check("t6_pre_beat", {y_first, y_last, y_label, y_data}, beat(0, 0, 3, 3));
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      mid();
      check("t6_rst_valid", y_valid, 0);
      check("t6_rst_ovf", overflow, 0);
      check("t6_rst_out", {y_first, y_last, y_label, y_data}, 0);
      cyc();
      clear_q();
      send(100, 3, 4); cyc();
      x_valid = 1'b0;
      drain("t6");
      add_vec(100, 3, 4);
      cmp_stream("t6");

      // push while full on the final beat of the head vector
      clear_q();
      send(0, 1, 0);  cyc();
      send(50, 2, 1); cyc();
      x_valid = 1'b0;
      repeat (6) cyc();
      mid();
      check("t4_last", {y_valid, y_last}, 2'b11);
      send(200, 1, 5);
      cyc();
      x_valid = 1'b0;
      mid();
      check("t4_ovf", overflow, 0);
      cyc();
      drain("t4");
      add_vec(0, 1, 0);
      add_vec(50, 2, 1);
      add_vec(200, 1, 5);
      cmp_stream("t4");
      check("t4_ovf_end", overflow, 0);

      // K=3, descending order, back-to-back vectors
      x2_valid = 1'b1; x2 = mkd(0, 1);  x2_label = mkl(0);
      cyc();
      x2 = mkd(10, 1); x2_label = mkl(2);
      mid(); check("t5_b0", {y2_valid, y2_first, y2_last, y2_label, y2_data}, {1'b1, beat(1, 0, 7, 7)});
      cyc();
      x2_valid = 1'b0;
      mid(); check("t5_b1", {y2_valid, y2_first, y2_last, y2_label, y2_data}, {1'b1, beat(0, 0, 6, 6)});
      cyc();
      mid(); check("t5_b2", {y2_valid, y2_first, y2_last, y2_label, y2_data}, {1'b1, beat(0, 1, 5, 5)});
      cyc();
      mid(); check("t5_b3", {y2_valid, y2_first, y2_last, y2_label, y2_data}, {1'b1, beat(1, 0, 1, 17)});
      cyc();
      mid(); check("t5_b4", {y2_valid, y2_first, y2_last, y2_label, y2_data}, {1'b1, beat(0, 0, 0, 16)});
      cyc();
      mid(); check("t5_b5", {y2_valid, y2_first, y2_last, y2_label, y2_data}, {1'b1, beat(0, 1, 7, 15)});
      cyc();
      mid();
      check("t5_idle", {y2_valid, busy2, overflow2}, 0);
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
